// File: rtl/span_traversal.sv
// Span traversal: walks a triangle's bounding box row by row and emits
// LANES-wide pixel beats with a coverage mask and the triangle's payload.
module span_traversal #(
    parameter int LANES     = 4,
    parameter int COORD_W   = 16,
    parameter int PAYLOAD_W = 64,
    parameter int ALIGN     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [COORD_W-1:0]   in_bbox_min_x,
    input  logic [COORD_W-1:0]   in_bbox_min_y,
    input  logic [COORD_W-1:0]   in_bbox_max_x,
    input  logic [COORD_W-1:0]   in_bbox_max_y,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W-1:0]   out_x,
    output logic [COORD_W-1:0]   out_y,
    output logic [LANES-1:0]     out_mask,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [COORD_W-1:0] ALIGN_MASK =
        (ALIGN == 1) ? ~COORD_W'(LANES - 1) : {COORD_W{1'b1}};
    localparam logic [COORD_W:0] LANE_STEP = (COORD_W + 1)'(LANES);

    state_t state;
    state_t state_next;

    logic [COORD_W-1:0]   min_x;
    logic [COORD_W-1:0]   max_x;
    logic [COORD_W-1:0]   max_y;
    logic [COORD_W-1:0]   row_start;
    logic [COORD_W-1:0]   x_q;
    logic [COORD_W-1:0]   y_q;
    logic [PAYLOAD_W-1:0] payload_q;

    logic degenerate;
    logic accept;
    logic advance;
    logic row_end;
    logic last_beat;

    assign degenerate = (in_bbox_min_x > in_bbox_max_x) || (in_bbox_min_y > in_bbox_max_y);
    assign accept     = in_valid && in_ready;
    assign advance    = out_valid && out_ready;
    // One extra bit keeps the end-of-row test honest near the top of the coordinate range.
    assign row_end    = ({1'b0, x_q} + LANE_STEP) > {1'b0, max_x};
    assign last_beat  = (y_q == max_y) && row_end;

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign out_valid   = (state == RUN);
    assign out_x       = x_q;
    assign out_y       = y_q;
    assign out_payload = payload_q;
    assign out_last    = (state == RUN) && last_beat;

    always_comb begin
        logic [COORD_W:0] lane_x;
        out_mask = '0;
        lane_x   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_x      = {1'b0, x_q} + (COORD_W + 1)'(i);
            out_mask[i] = (state == RUN) && (lane_x >= {1'b0, min_x}) && (lane_x <= {1'b0, max_x});
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && !degenerate) state_next = RUN;
            RUN:  if (advance && last_beat)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Bounds only matter while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            min_x     <= in_bbox_min_x;
            max_x     <= in_bbox_max_x;
            max_y     <= in_bbox_max_y;
            row_start <= in_bbox_min_x & ALIGN_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            x_q       <= '0;
            y_q       <= '0;
            payload_q <= '0;
        end else if (accept && !degenerate) begin
            x_q       <= in_bbox_min_x & ALIGN_MASK;
            y_q       <= in_bbox_min_y;
            payload_q <= in_payload;
        end else if (advance && !last_beat) begin
            if (row_end) begin
                x_q <= row_start;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + COORD_W'(LANES);
            end
        end
    end

endmodule

// File: tb/tb_span_traversal.sv
// Self-checking bench: two instances (ALIGN=0 and ALIGN=1) share stimulus and
// are compared every cycle against a bbox-enumeration model plus literal beats.
module tb_span_traversal;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [3:0]  mask;
        logic        last;
        logic [63:0] payload;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_min_x, in_min_y, in_max_x, in_max_y;
    logic [63:0] in_payload;
    logic        out_ready;

    logic        r0, v0, l0, b0;
    logic [15:0] x0, y0;
    logic [3:0]  m0;
    logic [63:0] p0;
    logic        r1, v1, l1, b1;
    logic [15:0] x1, y1;
    logic [3:0]  m1;
    logic [63:0] p1;

    beat_t q0[$], q1[$], obs0[$], obs1[$];
    int total = 0;
    int bad = 0;

    span_traversal #(.LANES(4), .COORD_W(16), .PAYLOAD_W(64), .ALIGN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0),
        .in_bbox_min_x(in_min_x), .in_bbox_min_y(in_min_y),
        .in_bbox_max_x(in_max_x), .in_bbox_max_y(in_max_y),
        .in_payload(in_payload), .out_valid(v0), .out_ready(out_ready),
        .out_x(x0), .out_y(y0), .out_mask(m0), .out_payload(p0),
        .out_last(l0), .busy(b0)
    );

    span_traversal #(.LANES(4), .COORD_W(16), .PAYLOAD_W(64), .ALIGN(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
        .in_bbox_min_x(in_min_x), .in_bbox_min_y(in_min_y),
        .in_bbox_max_x(in_max_x), .in_bbox_max_y(in_max_y),
        .in_payload(in_payload), .out_valid(v1), .out_ready(out_ready),
        .out_x(x1), .out_y(y1), .out_mask(m1), .out_payload(p1),
        .out_last(l1), .busy(b1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string name, input beat_t act, input beat_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got x=%0d y=%0d mask=%b last=%b pl=%h want x=%0d y=%0d mask=%b last=%b pl=%h",
                     name, act.x, act.y, act.mask, act.last, act.payload,
                     exp.x, exp.y, exp.mask, exp.last, exp.payload);
        end
    endtask

    // Enumerate every LANES-wide step of every row of the box.
    task automatic modelPush(input int which, input logic [15:0] mnx, input logic [15:0] mny,
                             input logic [15:0] mxx, input logic [15:0] mxy, input logic [63:0] pl);
        beat_t b;
        int start;
        if (mnx > mxx || mny > mxy) return;
        start = (which == 1) ? (int'(mnx) / 4) * 4 : int'(mnx);
        for (int y = int'(mny); y <= int'(mxy); y++) begin
            for (int x = start; x <= int'(mxx); x += 4) begin
                b.x = 16'(x);
                b.y = 16'(y);
                for (int i = 0; i < 4; i++)
                    b.mask[i] = (x + i >= int'(mnx)) && (x + i <= int'(mxx));
                b.last = (y == int'(mxy)) && (x + 4 > int'(mxx));
                b.payload = pl;
                if (which == 0) q0.push_back(b);
                else            q1.push_back(b);
            end
        end
    endtask

    task automatic monitorSide(input int which, input logic v, input logic bz, input logic ir, input beat_t b);
        int n;
        beat_t exp;
        n = (which == 0) ? q0.size() : q1.size();
        checkOutput($sformatf("busy_vs_valid%0d", which), {127'd0, bz}, {127'd0, v});
        checkOutput($sformatf("ready_vs_busy%0d", which), {127'd0, ir}, {127'd0, !bz});
        checkOutput($sformatf("valid%0d", which), {127'd0, v}, {127'd0, n > 0});
        if (v === 1'b1 && n > 0) begin
            exp = (which == 0) ? q0[0] : q1[0];
            checkBeat($sformatf("beat%0d", which), b, exp);
            if (out_ready) begin
                if (which == 0) begin void'(q0.pop_front()); obs0.push_back(b); end
                else            begin void'(q1.pop_front()); obs1.push_back(b); end
            end
        end
    endtask

    always @(negedge clk) begin
        monitorSide(0, v0, b0, r0, '{x0, y0, m0, l0, p0});
        monitorSide(1, v1, b1, r1, '{x1, y1, m1, l1, p1});
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else if (in_valid) begin
            if (r0) modelPush(0, in_min_x, in_min_y, in_max_x, in_max_y, in_payload);
            if (r1) modelPush(1, in_min_x, in_min_y, in_max_x, in_max_y, in_payload);
        end
    end

    // Returns just after the accepting edge, while the first beat is on the outputs.
    task automatic applyStimulus(input logic [15:0] mnx, input logic [15:0] mny,
                                 input logic [15:0] mxx, input logic [15:0] mxy, input logic [63:0] pl);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk); #2;
            if (r0 && r1) got = 1'b1;
        end
        checkOutput("accept_wait", {127'd0, got}, 128'd1);
        in_min_x = mnx; in_min_y = mny; in_max_x = mxx; in_max_y = mxy; in_payload = pl;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk); #2;
            if (!v0 && !v1 && q0.size() == 0 && q1.size() == 0) done = 1'b1;
        end
        checkOutput("idle_wait", {127'd0, done}, 128'd1);
    endtask

    task automatic expectObs(input int which, input int idx, input int x, input int y,
                             input logic [3:0] mask, input logic last);
        int n;
        beat_t b;
        n = (which == 0) ? obs0.size() : obs1.size();
        total++;
        if (idx >= n) begin
            bad++;
            $display("[TB] FAIL lit%0d_%0d: got no beat want x=%0d y=%0d", which, idx, x, y);
            return;
        end
        b = (which == 0) ? obs0[idx] : obs1[idx];
        if (b.x !== 16'(x) || b.y !== 16'(y) || b.mask !== mask || b.last !== last) begin
            bad++;
            $display("[TB] FAIL lit%0d_%0d: got x=%0d y=%0d mask=%b last=%b want x=%0d y=%0d mask=%b last=%b",
                     which, idx, b.x, b.y, b.mask, b.last, x, y, mask, last);
        end
    endtask

    task automatic expectCount(input int which, input int n);
        checkOutput($sformatf("count%0d", which),
                    128'((which == 0) ? obs0.size() : obs1.size()), 128'(n));
    endtask

    task automatic clearObs();
        obs0.delete();
        obs1.delete();
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_min_x = '0; in_min_y = '0; in_max_x = '0; in_max_y = '0; in_payload = '0;

        repeat (3) @(posedge clk);
        #2;
        checkOutput("rst_state0", {69'd0, v0, b0, l0, m0, x0, y0, r0},
                    {69'd0, 1'b0, 1'b0, 1'b0, 4'b0, 16'd0, 16'd0, 1'b1});
        checkOutput("rst_payload0", {64'd0, p0}, 128'd0);
        checkOutput("rst_state1", {69'd0, v1, b1, l1, m1, x1, y1, r1},
                    {69'd0, 1'b0, 1'b0, 1'b0, 4'b0, 16'd0, 16'd0, 1'b1});
        rst = 1'b1;

        // Two-row box, continuous out_ready.
        clearObs();
        applyStimulus(10, 5, 15, 6, 64'hA5A5_0000_1234_5678);
        waitIdle();
        expectCount(0, 4);
        expectObs(0, 0, 10, 5, 4'b1111, 0);
        expectObs(0, 1, 14, 5, 4'b0011, 0);
        expectObs(0, 2, 10, 6, 4'b1111, 0);
        expectObs(0, 3, 14, 6, 4'b0011, 1);
        expectCount(1, 4);
        expectObs(1, 0, 8, 5, 4'b1100, 0);
        expectObs(1, 1, 12, 5, 4'b1111, 0);
        expectObs(1, 3, 12, 6, 4'b1111, 1);

        // Single row, aligned start below min_x.
        clearObs();
        applyStimulus(10, 5, 13, 5, 64'h1111_2222_3333_4444);
        waitIdle();
        expectCount(1, 2);
        expectObs(1, 0, 8, 5, 4'b1100, 0);
        expectObs(1, 1, 12, 5, 4'b0011, 1);
        expectCount(0, 1);
        expectObs(0, 0, 10, 5, 4'b1111, 1);

        // Backpressure for three cycles on the second beat.
        clearObs();
        applyStimulus(10, 5, 15, 6, 64'hDEAD_BEEF_0000_0001);
        @(posedge clk); #2;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            checkOutput("stall_hold0", {91'd0, v0, x0, y0, m0}, {91'd0, 1'b1, 16'd14, 16'd5, 4'b0011});
        end
        out_ready = 1'b1;
        waitIdle();
        expectCount(0, 4);
        expectObs(0, 1, 14, 5, 4'b0011, 0);
        expectObs(0, 2, 10, 6, 4'b1111, 0);
        expectObs(0, 3, 14, 6, 4'b0011, 1);

        // Degenerate box is dropped; a 1x1 box gives one beat.
        clearObs();
        applyStimulus(20, 0, 19, 0, 64'h5);
        checkOutput("degen_idle0", {126'd0, v0, r0}, {126'd0, 1'b0, 1'b1});
        applyStimulus(0, 0, 0, 0, 64'h6);
        waitIdle();
        expectCount(0, 1);
        expectObs(0, 0, 0, 0, 4'b0001, 1);
        expectCount(1, 1);
        expectObs(1, 0, 0, 0, 4'b0001, 1);

        // Top-of-range corner: no lane or row wrap.
        clearObs();
        applyStimulus(65533, 65535, 65535, 65535, 64'h7);
        waitIdle();
        expectCount(0, 1);
        expectObs(0, 0, 65533, 65535, 4'b0111, 1);
        expectCount(1, 1);
        expectObs(1, 0, 65532, 65535, 4'b1110, 1);

        // Reset in the middle of a triangle.
        clearObs();
        applyStimulus(10, 5, 15, 6, 64'h8);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        checkOutput("rst_mid0", {124'd0, v0, b0, r0, l0}, {124'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        checkOutput("rst_mid1", {126'd0, v1, r1}, {126'd0, 1'b0, 1'b1});
        expectCount(0, 2);
        clearObs();
        applyStimulus(0, 0, 3, 0, 64'h9);
        waitIdle();
        expectCount(0, 1);
        expectObs(0, 0, 0, 0, 4'b1111, 1);
        expectCount(1, 1);
        expectObs(1, 0, 0, 0, 4'b1111, 1);

        // A wider mixed box driven through the model only.
        applyStimulus(3, 100, 21, 103, 64'hCAFE);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        out_ready = 1'b1;
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
